// File: rtl/twos_comp_pkg.sv
// Shared definitions for the serial two's-complement negator.
// The state encoding lives here so the testbench can check the FSM state
// with the same names the RTL uses.
package twos_comp_pkg;

  // PASS: no 1 seen yet in the current word; bits go through unchanged.
  // INVERT: the lowest 1 has already passed; every later bit is inverted.
  typedef enum logic {
    PASS   = 1'b0,
    INVERT = 1'b1
  } state_t;

  localparam logic OUT_RESET = 1'b0;

endpackage : twos_comp_pkg

// File: rtl/twos_comp.sv
// Serial two's-complement (negation) of an LSB-first bit stream.
// Bits up to and including the first 1 pass through; every later bit is
// inverted. A word has no fixed length: it starts at the first edge after
// reset and runs until the next reset. The result appears on out one clock
// after the bit is sampled, always from a flop.
module twos_comp
  import twos_comp_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic I,
  output logic out
);

  // NOTE: the declaration initialisers give a defined power-up value (PASS, 0)
  // even if res is never asserted; res still forces the same values.
  state_t state    = PASS;
  logic   out_q    = OUT_RESET;

  state_t next_state;
  logic   next_out;

  // Next-state and next-output decode for the two-state negator.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch
    // is inferred.
    next_state = state;
    next_out   = I;
    unique case (state)
      PASS: begin
        next_out = I;
        if (I) next_state = INVERT;
      end
      INVERT: begin
        next_out   = ~I;
        next_state = INVERT;
      end
      default: begin
        next_out   = OUT_RESET;
        next_state = PASS;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over data.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so both registers update from the
    // values sampled at the same edge.
    if (res) begin
      state <= PASS;
      out_q <= OUT_RESET;
    end else begin
      state <= next_state;
      out_q <= next_out;
    end
  end

  assign out = out_q;

`ifndef SYNTHESIS
  // Reset forces PASS and a 0 output on the following cycle.
  a_reset: assert property (@(posedge clk)
    res |=> (state == PASS) && (out == OUT_RESET));

  // In PASS the sampled bit is passed through and a 1 moves to INVERT.
  a_pass: assert property (@(posedge clk)
    (!res && state == PASS) |=>
      (out == $past(I)) && (state == ($past(I) ? INVERT : PASS)));

  // In INVERT the sampled bit is complemented and the state is held.
  a_invert: assert property (@(posedge clk)
    (!res && state == INVERT) |=> (out == !$past(I)) && (state == INVERT));
`endif

endmodule : twos_comp

// File: tb/tb_twos_comp.sv
// Self-checking bench for twos_comp. The reference model keeps the word
// received so far as an integer and takes bit k of its arithmetic negation;
// the expected state is INVERT exactly when that integer is non-zero.
module tb_twos_comp;
  import twos_comp_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic I   = 1'b0;
  logic out;

  twos_comp dut (
    .clk (clk),
    .res (res),
    .I   (I),
    .out (out)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  longint unsigned acc      = 0;   // value of the current word received so far
  int              k        = 0;   // index of the next bit within the word
  logic [63:0]     got_word = '0;  // out bits collected for the current word

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply res/I, clock them in, then compare against the model.
  task automatic step(input logic r, input logic d);
    longint unsigned neg;
    logic            exp_out;
    state_t          exp_state;
    res = r;
    I   = d;
    @(posedge clk);
    #1;
    if (r) begin
      acc     = 0;
      k       = 0;
      exp_out = 1'b0;
    end else begin
      acc      = acc | (longint'(d) << k);
      neg      = ~acc + 64'd1;
      exp_out  = neg[k];
      got_word[k] = out;
      k++;
    end
    exp_state = (acc != 0) ? INVERT : PASS;
    check("out", {63'd0, out}, {63'd0, exp_out});
    check("state", {63'd0, dut.state}, {63'd0, exp_state});
  endtask

  // Feed n bits of w LSB first, then compare the collected word to exp.
  task automatic feed(input string tag, input logic [63:0] w, input int n,
                      input logic [63:0] exp);
    got_word = '0;
    for (int i = 0; i < n; i++) step(1'b0, w[i]);
    check(tag, got_word, exp);
  endtask

  logic seq_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic seq_in  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic seq_res [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    // Power-up with res never asserted: register initial values must hold.
    feed("powerup_5772", 64'h5772, 16, 64'hA88E);

    step(1'b1, 1'b0);
    feed("word_5772", 64'h5772, 16, 64'hA88E);

    step(1'b1, 1'b1);
    feed("word_0000", 64'h0000, 16, 64'h0000);

    step(1'b1, 1'b0);
    feed("word_0001", 64'h0001, 16, 64'hFFFF);

    step(1'b1, 1'b0);
    feed("word_8000", 64'h8000, 16, 64'h8000);

    // Mid-word reset with I=1 on the reset edge.
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(seq_res[i], seq_in[i]);
      check($sformatf("abort_seq_%0d", i), {63'd0, out}, {63'd0, seq_exp[i]});
    end

    // Random words of random length, with occasional mid-word resets.
    for (int w = 0; w < 40; w++) begin
      int len;
      step(1'b1, 1'($urandom));
      len = $urandom_range(1, 48);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 24) == 0) step(1'b1, 1'($urandom));
        else                            step(1'b0, 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_twos_comp

// File: doc/twos_comp.md
TWOS_COMP -- requirements
Module: twos_comp

Interface
REQ-001 Parameters: none; data width is unbounded, and word boundaries are defined only by reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 res  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 I  input  1  serial operand bit, least-significant bit first, one bit per rising clk edge.
REQ-005 out  output  1  serial two's-complement result bit, LSB first, registered.

Function
REQ-006 The block SHALL compute the two's complement (negation modulo 2^N) of a serial word, for any word length N, starting from the first bit after reset.
REQ-007 The block SHALL use a two-state machine: state PASS means no 1 seen yet, and state INVERT means at least one 1 seen.
REQ-008 In PASS, on a rising edge with res=0, the block SHALL load out with I, and SHALL move to INVERT if I=1, otherwise stay in PASS.
REQ-009 In INVERT, on a rising edge with res=0, the block SHALL load out with the complement of I and SHALL stay in INVERT.
REQ-010 Latency SHALL be one clock: the result for the bit presented before edge k SHALL be valid on out from edge k until edge k+1.
REQ-011 out SHALL be driven only from a flop and SHALL NOT combinationally depend on I.
REQ-012 The block SHALL have no handshake: every rising edge with res=0 consumes exactly one input bit.
REQ-013 Word boundary: the block SHALL remain in INVERT indefinitely; a new word requires asserting res.
REQ-014 Input 0 word: out SHALL stay 0 and the state SHALL stay PASS.
REQ-015 Most-negative input (1 followed by all 0s in the upper bits, e.g. 0x8000 for N=16): out SHALL equal the input.

Reset
REQ-016 When res=1 at a rising edge, state SHALL become PASS and out SHALL become 0, regardless of I.
REQ-017 When res and I=1 occur on the same edge, reset SHALL win, and that bit SHALL NOT be treated as data.
REQ-018 Reset asserted mid-word SHALL abort the word, and the next non-reset edge SHALL be treated as bit 0 of a new word.
REQ-019 State and out registers SHALL also carry a power-up/initial value of PASS and 0, so a bench that deasserts res before the first clock edge still starts in a defined state.
REQ-020 On a clock edge, res SHALL have no effect unless res is sampled high.

Structure
REQ-021 The state encoding (PASS=0, INVERT=1) SHALL be defined as a typedef/constants in package twos_comp_pkg, shared with the testbench for state checks.
REQ-022 The module SHALL contain the following, with no sub-module:
- one state register;
- one output register;
- next-state/output logic;
- an optional assertion block, excluded from synthesis, checking REQ-008 to REQ-016.
REQ-023 The design SHALL use no latches and SHALL use a single clock domain.

Verification
REQ-024 Stimulus: reset, then serial 0x5772 LSB first (0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0). Required response: out sequence 0,1,1,1,0,0,0,1,0,0,0,1,0,1,0,1, i.e. 0xA88E.
REQ-025 Stimulus: reset, then 16 zero bits. Required response: out = 0 on every cycle and state PASS throughout.
REQ-026 Stimulus: reset, then 0x0001 (1 then fifteen 0s). Required response: out = 1 on every cycle, i.e. 0xFFFF.
REQ-027 Stimulus: reset, then 0x8000. Required response: out = fifteen 0s then 1, i.e. 0x8000.
REQ-028 Stimulus: feed 0,1,0, then assert res with I=1 for one edge, then feed 1,1. Required response:
- out is 0,1,1 before the reset;
- out is 0 at the reset edge;
- out is 1,0 afterwards, i.e. the post-reset bit 1 is passed, not inverted.
REQ-029 Stimulus: start from power-up with res deasserted before any edge, then feed 0x5772. Required response: same output as REQ-024, with no X on out.
